// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: packs a big-endian byte stream into 32-bit words and
// appends SHA-256 padding (0x80, zero fill, 64-bit bit length), emitting
// 16-word blocks with first/last-of-block and last-of-message flags.
module sha256_msg_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic        clk_axi,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] m_word,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_first,
    output logic        m_blk_last,
    output logic        m_msg_last
);

    localparam int unsigned CNT_W = LEN_W - 3;

    localparam logic [2:0] ST_DATA   = 3'd0;
    localparam logic [2:0] ST_PAD80  = 3'd1;
    localparam logic [2:0] ST_PADZ   = 3'd2;
    localparam logic [2:0] ST_LEN_HI = 3'd3;
    localparam logic [2:0] ST_LEN_LO = 3'd4;
    // Holds off new input until the final length word has been taken.
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [1:0]       byte_pos_q, byte_pos_d;
    logic [3:0]       word_pos_q, word_pos_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [23:0]      acc_q, acc_d;
    logic [31:0]      m_word_q, m_word_d;
    logic             m_valid_q, m_valid_d;
    logic             m_first_q, m_first_d;
    logic             m_blk_last_q, m_blk_last_d;
    logic             m_msg_last_q, m_msg_last_d;

    logic             reg_free;
    logic             s_ready_int;
    logic [LEN_W-1:0] bit_len;
    logic             inj_en;
    logic [7:0]       inj_byte;
    logic             load_en;
    logic [31:0]      load_word;
    logic             load_msg_last;

    assign reg_free    = !m_valid_q || m_ready;
    assign s_ready_int = (state_q == ST_DATA) && reg_free;
    assign bit_len     = {byte_cnt_q, 3'b000};

    assign s_ready    = s_ready_int;
    assign m_word     = m_word_q;
    assign m_valid    = m_valid_q;
    assign m_first    = m_first_q;
    assign m_blk_last = m_blk_last_q;
    assign m_msg_last = m_msg_last_q;

    // Next-state: FSM, byte packing and output register load
    always_comb begin
        state_d       = state_q;
        byte_pos_d    = byte_pos_q;
        word_pos_d    = word_pos_q;
        byte_cnt_d    = byte_cnt_q;
        acc_d         = acc_q;
        m_word_d      = m_word_q;
        m_valid_d     = m_valid_q;
        m_first_d     = m_first_q;
        m_blk_last_d  = m_blk_last_q;
        m_msg_last_d  = m_msg_last_q;
        inj_en        = 1'b0;
        inj_byte      = 8'h00;
        load_en       = 1'b0;
        load_word     = '0;
        load_msg_last = 1'b0;

        if (reg_free) begin
            m_valid_d    = 1'b0;
            m_first_d    = 1'b0;
            m_blk_last_d = 1'b0;
            m_msg_last_d = 1'b0;
        end

        case (state_q)
            ST_DATA: begin
                if (s_valid && s_ready_int) begin
                    inj_en     = 1'b1;
                    inj_byte   = s_data;
                    byte_cnt_d = byte_cnt_q + CNT_ONE;
                    if (s_last) begin
                        state_d = ST_PAD80;
                    end
                end
            end
            ST_PAD80: begin
                if (reg_free) begin
                    inj_en   = 1'b1;
                    inj_byte = 8'h80;
                    state_d  = ST_PADZ;
                end
            end
            ST_PADZ: begin
                if (reg_free) begin
                    if (byte_pos_q != 2'd0) begin
                        inj_en   = 1'b1;
                        inj_byte = 8'h00;
                    end else if (word_pos_q != 4'd14) begin
                        load_en   = 1'b1;
                        load_word = '0;
                    end else begin
                        state_d = ST_LEN_HI;
                    end
                end
            end
            ST_LEN_HI: begin
                if (reg_free) begin
                    load_en   = 1'b1;
                    load_word = bit_len[LEN_W-1 -: 32];
                    state_d   = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (reg_free) begin
                    load_en       = 1'b1;
                    load_word     = bit_len[31:0];
                    load_msg_last = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (m_ready) begin
                    byte_cnt_d = '0;
                    byte_pos_d = 2'd0;
                    word_pos_d = 4'd0;
                    state_d    = ST_DATA;
                end
            end
            default: begin
                state_d = ST_DATA;
            end
        endcase

        // Data, 0x80 and zero-fill bytes share one packing path
        if (inj_en) begin
            if (byte_pos_q == 2'd3) begin
                load_en   = 1'b1;
                load_word = {acc_q, inj_byte};
            end else begin
                case (byte_pos_q)
                    2'd0:    acc_d[23:16] = inj_byte;
                    2'd1:    acc_d[15:8]  = inj_byte;
                    default: acc_d[7:0]   = inj_byte;
                endcase
            end
            byte_pos_d = byte_pos_q + 2'd1;
        end

        if (load_en) begin
            m_word_d     = load_word;
            m_valid_d    = 1'b1;
            m_first_d    = (word_pos_q == 4'd0);
            m_blk_last_d = (word_pos_q == 4'd15) || load_msg_last;
            m_msg_last_d = load_msg_last;
            word_pos_d   = word_pos_q + 4'd1;
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk_axi or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_DATA;
            byte_pos_q   <= 2'd0;
            word_pos_q   <= 4'd0;
            byte_cnt_q   <= '0;
            acc_q        <= '0;
            m_word_q     <= '0;
            m_valid_q    <= 1'b0;
            m_first_q    <= 1'b0;
            m_blk_last_q <= 1'b0;
            m_msg_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_pos_q   <= byte_pos_d;
            word_pos_q   <= word_pos_d;
            byte_cnt_q   <= byte_cnt_d;
            acc_q        <= acc_d;
            m_word_q     <= m_word_d;
            m_valid_q    <= m_valid_d;
            m_first_q    <= m_first_d;
            m_blk_last_q <= m_blk_last_d;
            m_msg_last_q <= m_msg_last_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Testbench for sha256_msg_padder: directed messages checked against a
// padding model built from byte arrays, with backpressure and mid-message reset.
module tb_sha256_msg_padder;

    logic        clk_axi;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] m_word;
    logic        m_valid;
    logic        m_ready;
    logic        m_first;
    logic        m_blk_last;
    logic        m_msg_last;

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk_axi   (clk_axi),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_word    (m_word),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_first   (m_first),
        .m_blk_last(m_blk_last),
        .m_msg_last(m_msg_last)
    );

    initial clk_axi = 1'b0;
    always #5 clk_axi = ~clk_axi;

    typedef struct packed {
        logic [31:0] w;
        logic        f;
        logic        b;
        logic        m;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  msg_buf[0:255];
    logic [31:0] mw[0:63];
    int          nw;
    int          n_cmp;
    int          n_fail;
    bit          bp_mode;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Padded message per FIPS 180-4 built as a byte array, then cut into words
    function automatic void model(input int len);
        logic [7:0]  p[0:255];
        logic [63:0] bl;
        int          tot;
        tot = ((len + 9 + 63) / 64) * 64;
        bl  = 64'(len) * 64'd8;
        for (int i = 0; i < tot; i++) begin
            if (i < len)       p[i] = msg_buf[i];
            else if (i == len) p[i] = 8'h80;
            else               p[i] = 8'h00;
        end
        for (int k = 0; k < 8; k++) p[tot - 8 + k] = bl[63 - 8 * k -: 8];
        nw = tot / 4;
        for (int i = 0; i < nw; i++) mw[i] = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
    endfunction

    function automatic void push_exp();
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back({mw[i], (i % 16) == 0, (i % 16) == 15, i == nw - 1});
        end
    endfunction

    function automatic void load_abc();
        msg_buf[0] = 8'h61;
        msg_buf[1] = 8'h62;
        msg_buf[2] = 8'h63;
    endfunction

    function automatic void load_ramp(input int len);
        for (int i = 0; i < len; i++) msg_buf[i] = 8'(i * 7 + 1);
    endfunction

    task automatic send(input int len, input bit last_on);
        int t;
        for (int i = 0; i < len; i++) begin
            s_data  = msg_buf[i];
            s_valid = 1'b1;
            s_last  = last_on && (i == len - 1);
            t = 0;
            forever begin
                @(negedge clk_axi);
                if (s_ready) break;
                t++;
                if (t > 500) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL s_ready_timeout: byte %0d never accepted, expected acceptance", i);
                    break;
                end
            end
            @(posedge clk_axi);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk_axi);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk_axi);
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        bp_mode = 1'b0;
        rst_n   = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;

        fork
            // Downstream ready: always 1, or the 1,0,0,1 stall pattern
            begin
                int cyc;
                cyc = 0;
                forever begin
                    @(posedge clk_axi);
                    #1;
                    if (bp_mode) m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                    else         m_ready = 1'b1;
                    cyc++;
                end
            end
            // Output checker: every handshake against the model, plus stall stability
            begin
                bit          stall_prev;
                bit          after_msg;
                logic [34:0] held;
                exp_t        e;
                stall_prev = 1'b0;
                after_msg  = 1'b0;
                held       = '0;
                forever begin
                    @(negedge clk_axi);
                    if (!rst_n) begin
                        stall_prev = 1'b0;
                        after_msg  = 1'b0;
                    end else begin
                        if (stall_prev)
                            chk("stall_hold", {29'd0, m_valid, m_word, m_first, m_blk_last, m_msg_last},
                                {29'd0, 1'b1, held});
                        if (after_msg) chk("s_ready_after_msg", 64'(s_ready), 64'd1);
                        after_msg = 1'b0;
                        if (m_valid && !m_ready) begin
                            chk("s_ready_stalled", 64'(s_ready), 64'd0);
                            stall_prev = 1'b1;
                            held = {m_word, m_first, m_blk_last, m_msg_last};
                        end else begin
                            stall_prev = 1'b0;
                        end
                        if (m_valid && m_ready) begin
                            if (exp_q.size() == 0) begin
                                n_cmp++;
                                n_fail++;
                                $display("FAIL stray_word: got %h, expected no word", m_word);
                            end else begin
                                e = exp_q.pop_front();
                                chk("word", {29'd0, m_word, m_first, m_blk_last, m_msg_last},
                                    {29'd0, e.w, e.f, e.b, e.m});
                                if (e.m) begin
                                    chk("s_ready_on_final", 64'(s_ready), 64'd0);
                                    after_msg = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk_axi);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_word", 64'(m_word), 64'd0);
        chk("rst_flags", {61'd0, m_first, m_blk_last, m_msg_last}, 64'd0);
        @(posedge clk_axi);
        #1;
        rst_n = 1'b1;

        // Hand-computed pins on the model
        load_abc();
        model(3);
        chk("model_abc_nw", 64'(nw), 64'd16);
        chk("model_abc_w0", 64'(mw[0]), 64'h61626380);
        chk("model_abc_w14", 64'(mw[14]), 64'h0);
        chk("model_abc_w15", 64'(mw[15]), 64'h18);
        load_ramp(55);
        model(55);
        chk("model_55_nw", 64'(nw), 64'd16);
        chk("model_55_w13lo", 64'(mw[13][7:0]), 64'h80);
        chk("model_55_len", {mw[14], mw[15]}, 64'h1B8);
        load_ramp(56);
        model(56);
        chk("model_56_nw", 64'(nw), 64'd32);
        chk("model_56_w14", 64'(mw[14]), 64'h80000000);
        chk("model_56_len", {mw[30], mw[31]}, 64'h1C0);
        load_ramp(64);
        model(64);
        chk("model_64_nw", 64'(nw), 64'd32);
        chk("model_64_w16", 64'(mw[16]), 64'h80000000);
        chk("model_64_len", 64'(mw[31]), 64'h200);

        // "abc", no backpressure
        load_abc();
        model(3);
        push_exp();
        send(3, 1'b1);
        drain();

        // Block-boundary lengths
        for (int k = 0; k < 3; k++) begin
            int len;
            len = (k == 0) ? 55 : (k == 1) ? 56 : 64;
            load_ramp(len);
            model(len);
            push_exp();
            send(len, 1'b1);
            drain();
        end

        // Backpressure, two back-to-back "abc" messages
        bp_mode = 1'b1;
        load_abc();
        model(3);
        push_exp();
        push_exp();
        send(3, 1'b1);
        send(3, 1'b1);
        drain();
        bp_mode = 1'b0;
        repeat (2) @(posedge clk_axi);
        #1;

        // Reset mid-message: two full words leave before reset, the rest is dropped
        load_ramp(10);
        exp_q.push_back({msg_buf[0], msg_buf[1], msg_buf[2], msg_buf[3], 1'b1, 1'b0, 1'b0});
        exp_q.push_back({msg_buf[4], msg_buf[5], msg_buf[6], msg_buf[7], 1'b0, 1'b0, 1'b0});
        send(10, 1'b0);
        drain();
        rst_n = 1'b0;
        @(negedge clk_axi);
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_m_word", 64'(m_word), 64'd0);
        @(posedge clk_axi);
        #1;
        rst_n = 1'b1;
        load_abc();
        model(3);
        push_exp();
        send(3, 1'b1);
        drain();
        repeat (10) @(posedge clk_axi);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Front-end stage feeding the SHA-256 compression core in the snickerbits top level.
- Accepts a big-endian byte stream per message and emits 32-bit words in 16-word (512-bit) blocks.
- Applies FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit message bit length.
- Marks block and message boundaries so the core can start and finish rounds without further bookkeeping.

Parameters:
- LEN_W, 64, width of the bit-length field. Fixed at 64 for SHA-256; the byte counter is LEN_W-3 bits wide.

Ports:
- clk_axi  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- s_data  in  8  message byte
- s_valid  in  1  s_data valid
- s_last  in  1  final byte of message; qualified by s_valid
- s_ready  out  1  padder accepts a byte this cycle
- m_word  out  32  block word, big-endian packed
- m_valid  out  1  m_word valid
- m_ready  in  1  downstream accepts m_word
- m_first  out  1  word 0 of a block
- m_blk_last  out  1  word 15 of a block
- m_msg_last  out  1  word 15 of the final block of a message

Behaviour:
- Reset (async, rst_n low):
  - m_word=0; m_valid, m_first, m_blk_last, m_msg_last all 0.
  - byte_pos, word_pos and byte_cnt cleared; state=DATA.
  - Reset mid-message discards all partial state; no word is emitted for it.
- Output register:
  - The output register is "free" when m_valid=0 or m_ready=1 in the same cycle.
  - A word is loaded only when the register is free.
  - m_word and all flags hold stable while m_valid=1 and m_ready=0.
- Byte packing:
  - Each accepted byte goes into lane (3-byte_pos) of the word accumulator, i.e. the first byte lands in bits [31:24].
  - When the 4th byte is packed, the completed word is loaded into the output register. m_valid rises the cycle after that byte is accepted (1-cycle latency).
  - word_pos increments per word loaded and wraps 15->0.
  - Flags on each loaded word: m_first = (word_pos==0); m_blk_last = (word_pos==15).
- s_ready = (state==DATA) && register free. It stays 0 from the cycle after s_last is accepted until the LEN_LO word handshakes.
- byte_cnt increments per accepted data byte and wraps modulo 2^61. Bit length is {byte_cnt,3'b000}.
- FSM:
  - DATA: accept bytes. On an accepted byte with s_last=1 -> PAD80.
  - PAD80: when the register is free, inject byte 0x80 through the same packing path -> PADZ.
  - PADZ: when the register is free:
    - if byte_pos!=0, inject a 0x00 byte;
    - else if word_pos!=14, load a full zero word in one cycle;
    - else (byte_pos==0 and word_pos==14) -> LEN_HI without loading.
  - LEN_HI: load len[63:32] -> LEN_LO.
  - LEN_LO: load len[31:0] with m_blk_last=1 and m_msg_last=1 -> DATA. byte_cnt and positions are cleared on the handshake of this word.
- Boundary cases:
  - If s_last completes byte_pos=3, the 0x80 starts a new word.
  - If 0x80 lands at or beyond byte 56 of a block, PADZ fills the rest of that block plus 56 bytes of the next one.
  - Blocks per message = ceil((L+9)/64), where L is the message length in bytes.
  - A new message's first byte is accepted in the same cycle the LEN_LO word handshakes only if state is already DATA. It is not; the first byte is accepted the cycle after.
  - Zero-length messages are unsupported, since s_last always carries a byte.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63), m_ready=1:
  - 16 words: 0x61626380, 13x 0x00000000, 0x00000000, 0x00000018.
  - m_first on word 0 only; m_blk_last and m_msg_last on word 15.
- 55-byte message: exactly one block; word 13 low byte = 0x80; words 14-15 = 0x00000000_000001B8.
- 56-byte message: two blocks.
  - Block 1: word 14 = 0x80000000, word 15 = 0, m_blk_last=1, m_msg_last=0.
  - Block 2: words 0-13 zero, length 0x1C0, m_msg_last=1.
- 64-byte message: two blocks; block 2 word 0 = 0x80000000, final word = 0x00000200.
- Backpressure on "abc":
  - m_ready pattern 1,0,0,1 repeating.
  - Word sequence must be identical to the unstalled case; m_word stable while stalled.
  - s_ready=0 whenever m_valid=1 and m_ready=0.
- Reset mid-message: assert rst_n=0 after 10 bytes, release, then send "abc". Output must equal the "abc" case exactly, with no stray words.
